// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences start/data/parity/stop bits on an
// oversampling clock. It drives the sample, check and shift strobes for the
// external sampler/checkers/deserializer, and it reports an accepted frame.
//
// Output semantics: data_valid is a one-cycle pulse with no ready side.
// It is asserted in the cycle after the last stop-bit edge, and only when the
// stop checker and the latched parity result were both clean.
// All strobes are registered. Each is computed from the next-cycle state and
// counters, so in any cycle it matches the edge_cnt/bit_cnt shown in that cycle.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       dat_samp_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       deser_en,
  output logic       data_valid,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state, nxt_state;
  logic [5:0] p_lat, nxt_p, nxt_edge, p_sel, half;
  logic [3:0] nxt_bit;
  logic       par_lat, nxt_par, frame_err, nxt_ferr, nxt_valid;
  logic       bit_done, active, strobe_hit;
  logic       nxt_samp, nxt_strt, nxt_deser, nxt_parchk, nxt_stp;

  // Unsupported ratios fall back to 8 so a bad Prescale can never stall a frame.
  assign p_sel     = (Prescale == 6'd16 || Prescale == 6'd32) ? Prescale : 6'd8;
  assign bit_done  = (edge_cnt == p_lat - 6'd1);
  assign dbg_state = state;

  // Next state, counters, frame latches and the accept decision.
  always_comb begin
    nxt_state = state;
    nxt_edge  = edge_cnt;
    nxt_bit   = bit_cnt;
    nxt_p     = p_lat;
    nxt_par   = par_lat;
    nxt_ferr  = frame_err;
    nxt_valid = 1'b0;
    if (state == IDLE) begin
      nxt_edge = 6'd0;
      nxt_bit  = 4'd0;
      if (!RX_IN) begin
        nxt_state = START;
        nxt_p     = p_sel;
        nxt_par   = PAR_EN;
        nxt_ferr  = 1'b0;
      end
    end else begin
      if (bit_done) begin
        nxt_edge = 6'd0;
        nxt_bit  = bit_cnt + 4'd1;
      end else begin
        nxt_edge = edge_cnt + 6'd1;
      end
      if (bit_done) begin
        case (state)
          START: begin
            if (strt_glitch) begin
              nxt_state = IDLE;
              nxt_bit   = 4'd0;
            end else begin
              nxt_state = DATA;
            end
          end
          DATA: begin
            if (bit_cnt == 4'(DATA_WIDTH)) nxt_state = par_lat ? PARITY : STOP;
          end
          PARITY: begin
            nxt_state = STOP;
            if (par_err) nxt_ferr = 1'b1;
          end
          STOP: begin
            nxt_valid = !stp_err && !frame_err;
            nxt_bit   = 4'd0;
            // A low line on the final stop edge is the next start bit.
            if (!RX_IN) begin
              nxt_state = START;
              nxt_p     = p_sel;
              nxt_par   = PAR_EN;
              nxt_ferr  = 1'b0;
            end else begin
              nxt_state = IDLE;
            end
          end
          default: nxt_state = IDLE;
        endcase
      end
    end
  end

  // Strobe decode from the next-cycle position, so the registered strobes line up with the counters.
  always_comb begin
    half       = nxt_p >> 1;
    active     = (nxt_state != IDLE);
    nxt_samp   = active && (nxt_edge == half - 6'd1 || nxt_edge == half ||
                            nxt_edge == half + 6'd1);
    strobe_hit = active && (nxt_edge == half + 6'd2);
    nxt_strt   = strobe_hit && (nxt_state == START);
    nxt_deser  = strobe_hit && (nxt_state == DATA);
    nxt_parchk = strobe_hit && (nxt_state == PARITY);
    nxt_stp    = strobe_hit && (nxt_state == STOP);
  end

  // Controller state and all registered outputs; reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      edge_cnt    <= 6'd0;
      bit_cnt     <= 4'd0;
      p_lat       <= 6'd8;
      par_lat     <= 1'b0;
      frame_err   <= 1'b0;
      data_valid  <= 1'b0;
      dat_samp_en <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
    end else begin
      state       <= nxt_state;
      edge_cnt    <= nxt_edge;
      bit_cnt     <= nxt_bit;
      p_lat       <= nxt_p;
      par_lat     <= nxt_par;
      frame_err   <= nxt_ferr;
      data_valid  <= nxt_valid;
      dat_samp_en <= nxt_samp;
      strt_chk_en <= nxt_strt;
      deser_en    <= nxt_deser;
      par_chk_en  <= nxt_parchk;
      stp_chk_en  <= nxt_stp;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl. Each launched frame is expanded into a list of the
// strobe events it must produce: {kind, cycle stamp, edge_cnt, bit_cnt}.
// The list is computed from the frame's bit layout and timing rules. A monitor
// pops and compares one entry for every strobe the DUT raises.
module tb_uart_rx_ctrl;
  localparam int DW = 8;
  localparam int EW = 33;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;
  logic [2:0] dbg_state;

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .deser_en(deser_en), .data_valid(data_valid), .dbg_state(dbg_state)
  );

  // Clock and cycle stamp; the stamp is stable at every negedge.
  always #5 CLK = ~CLK;
  logic [19:0] cyc = '0;
  always @(posedge CLK) cyc <= cyc + 20'd1;

  typedef struct {
    logic [5:0] ps;
    bit         pe;
    bit         glitch;
    bit         perr;
    bit         serr;
    logic [7:0] data;
    int         abort_k;
  } frame_t;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int eff_p(input logic [5:0] ps);
    return (ps == 6'd16) ? 16 : (ps == 6'd32) ? 32 : 8;
  endfunction

  function automatic int frame_bits(input frame_t f);
    return f.glitch ? 1 : (2 + DW + (f.pe ? 1 : 0));
  endfunction

  function automatic frame_t mk(input int ps, input bit pe, input bit gl, input bit perr,
                                input bit serr, input int data, input int abort_k);
    frame_t f;
    f.ps = 6'(ps); f.pe = pe; f.glitch = gl; f.perr = perr; f.serr = serr;
    f.data = 8'(data); f.abort_k = abort_k;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    int r;
    r = int'($urandom_range(0, 3));
    f.ps = (r == 0) ? 6'd8 : (r == 1) ? 6'd16 : (r == 2) ? 6'd32 : 6'($urandom_range(0, 63));
    f.pe = 1'($urandom_range(0, 1));
    f.glitch = ($urandom_range(0, 5) == 0);
    f.perr = ($urandom_range(0, 3) == 0);
    f.serr = ($urandom_range(0, 3) == 0);
    f.data = 8'($urandom_range(0, 255));
    f.abort_k = 0;
    return f;
  endfunction

  task automatic push_ev(input int kind, input int t, input int e, input int b);
    exp_q.push_back({3'(kind), 20'(t), 6'(e), 4'(b)});
  endtask

  // Scoreboard side: start a frame on this negedge and enqueue its expected events.
  task automatic launch(input frame_t f);
    int p, nb, t0, lim, role;
    RX_IN = 1'b0; Prescale = f.ps; PAR_EN = f.pe;
    p  = eff_p(f.ps);
    nb = frame_bits(f);
    t0 = int'(cyc) + 1;
    lim = (f.abort_k > 0) ? t0 + f.abort_k : t0 + nb * p + 1;
    for (int b = 0; b < nb; b++) begin
      role = (b == 0) ? 1 : (b <= DW) ? 2 : (f.pe && b == DW + 1) ? 3 : 4;
      for (int e = p / 2 - 1; e <= p / 2 + 1; e++)
        if (t0 + b * p + e <= lim) push_ev(0, t0 + b * p + e, e, b);
      if (t0 + b * p + p / 2 + 2 <= lim) push_ev(role, t0 + b * p + p / 2 + 2, p / 2 + 2, b);
    end
    if (!f.glitch && f.abort_k == 0 && !(f.pe && f.perr) && !f.serr)
      push_ev(5, t0 + nb * p, 0, 0);
  endtask

  task automatic check_zero(input string name);
    logic [15:0] got;
    got = {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
           deser_en, data_valid};
    n_cmp++;
    if (got !== 16'd0) begin
      n_bad++;
      $display("FAIL %s: outputs=%h expected 0000", name, got);
    end
  endtask

  // Driver: serial line plus checker results; the results are noise except at each bit's last edge.
  task automatic drive_frame(input frame_t f, input bit chain, input frame_t nf);
    int p, nb, nk, b, e;
    bit aborted;
    p = eff_p(f.ps); nb = frame_bits(f); nk = nb * p; aborted = 0;
    for (int k = 0; k < nk; k++) begin
      @(negedge CLK);
      b = k / p; e = k % p;
      Prescale    = 6'($urandom_range(0, 63));
      PAR_EN      = 1'($urandom_range(0, 1));
      strt_glitch = 1'($urandom_range(0, 1));
      par_err     = 1'($urandom_range(0, 1));
      stp_err     = 1'($urandom_range(0, 1));
      if (e == p - 1) begin
        if (b == 0) strt_glitch = f.glitch;
        else if (f.pe && b == DW + 1) par_err = f.perr;
        else if (b == nb - 1) stp_err = f.serr;
      end
      if (b == 0) RX_IN = f.glitch ? ((k < 4) ? 1'b0 : 1'b1) : 1'b0;
      else if (b <= DW) RX_IN = f.data[b - 1];
      else if (f.pe && b == DW + 1) RX_IN = ^f.data;
      else RX_IN = 1'b1;
      if (chain && k == nk - 1) launch(nf);
      if (f.abort_k > 0 && k == f.abort_k) begin
        #2 RST = 1'b0;
        #1 check_zero("reset_abort");
        @(negedge CLK);
        @(negedge CLK);
        RX_IN = 1'b1;
        RST = 1'b1;
        aborted = 1;
        break;
      end
    end
    if (!chain && !aborted) begin
      @(negedge CLK);
      RX_IN = 1'b1;
      n_cmp++;
      if ({edge_cnt, bit_cnt} !== 10'd0) begin
        n_bad++;
        $display("FAIL idle_counters: edge_cnt=%0d bit_cnt=%0d expected 0/0", edge_cnt, bit_cnt);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_IN = 1'b1;
      Prescale = 6'($urandom_range(0, 63));
      PAR_EN = 1'($urandom_range(0, 1));
      strt_glitch = 1'($urandom_range(0, 1));
      par_err = 1'($urandom_range(0, 1));
      stp_err = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_event(input logic [2:0] kind);
    logic [EW-1:0] got, exp;
    got = {kind, cyc, edge_cnt, bit_cnt};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: unexpected kind=%0d t=%0d edge=%0d bit=%0d", kind, cyc, edge_cnt, bit_cnt);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_bad++;
        $display("FAIL event: got kind=%0d t=%0d edge=%0d bit=%0d, expected kind=%0d t=%0d edge=%0d bit=%0d",
                 got[32:30], got[29:10], got[9:4], got[3:0],
                 exp[32:30], exp[29:10], exp[9:4], exp[3:0]);
      end
    end
  endtask

  // Monitor: every raised strobe must match the head of the expected queue.
  always @(negedge CLK) begin
    if (dat_samp_en) check_event(3'd0);
    if (strt_chk_en) check_event(3'd1);
    if (deser_en)    check_event(3'd2);
    if (par_chk_en)  check_event(3'd3);
    if (stp_chk_en)  check_event(3'd4);
    if (data_valid)  check_event(3'd5);
  end

  initial begin
    frame_t f, g, cur, nxt;
    bit chain;
    repeat (3) @(negedge CLK);
    check_zero("reset_state");
    RST = 1'b1;
    idle(3);
    // Clean 0xA5 at P=8, no parity.
    f = mk(8, 0, 0, 0, 0, 8'hA5, 0);
    launch(f); drive_frame(f, 0, f); idle(4);
    // P=16 with parity error: no accept.
    f = mk(16, 1, 0, 1, 0, 8'h3B, 0);
    launch(f); drive_frame(f, 0, f); idle(4);
    // P=32 false start.
    f = mk(32, 0, 1, 0, 0, 8'h00, 0);
    launch(f); drive_frame(f, 0, f); idle(2);
    // Back-to-back frames at P=8.
    f = mk(8, 0, 0, 0, 0, 8'h3C, 0);
    g = mk(8, 0, 0, 0, 0, 8'hC3, 0);
    launch(f); drive_frame(f, 1, g); drive_frame(g, 0, g); idle(3);
    // Illegal ratio 12 behaves as 8; mid-frame Prescale noise includes 16.
    f = mk(12, 1, 0, 0, 0, 8'h5A, 0);
    launch(f); drive_frame(f, 0, f); idle(3);
    // Reset in data bit 4, then a clean frame.
    f = mk(8, 0, 0, 0, 0, 8'h77, 4 * 8 + 2);
    launch(f); drive_frame(f, 0, f); idle(3);
    f = mk(8, 1, 0, 0, 0, 8'h81, 0);
    launch(f); drive_frame(f, 0, f); idle(3);
    // Stop error at P=16.
    f = mk(16, 0, 0, 0, 1, 8'hF0, 0);
    launch(f); drive_frame(f, 0, f); idle(3);
    // Random frames, sometimes chained.
    cur = rand_frame();
    launch(cur);
    for (int i = 0; i < 40; i++) begin
      chain = !cur.glitch && ($urandom_range(0, 2) == 0);
      nxt = rand_frame();
      drive_frame(cur, chain, nxt);
      if (!chain) begin
        idle(int'($urandom_range(0, 6)));
        launch(nxt);
      end
      cur = nxt;
    end
    drive_frame(cur, 0, cur);
    idle(10);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected events never seen, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
